bsg_manycore_eva_to_npa_pipe: RTL and testbench
===============================================

// Module: bsg_manycore_eva_to_npa_pipe
// PURPOSE
//  Pipelined, flow-controlled EVA->NPA translator for endpoints that issue remote requests. Classifies 32-bit EVA
//  as DRAM/global/tile-group/invalid and emits x,y-cord and word EPA. Adds a runtime-programmable DRAM mode
//  (striping on/off, XOR bank hashing), 1 or 2 DRAM rows, and a valid/ready interface. Sits between core/accelerator
//  request logic and the network link.
// PARAMETERS
//  data_width_p                  32    EVA width (fixed 32)
//  addr_width_p                  28    EPA width (word address)
//  x_cord_width_p / y_cord_width_p 7/7  coordinate widths
//  num_tiles_x_p                 16    DRAM columns; power of two
//  num_tiles_y_p                 8     tile rows; bottom DRAM row at y=num_tiles_y_p+1
//  num_dram_rows_p               2     1: bottom row only; 2: top (y=0) and bottom
//  vcache_block_size_in_words_p  8     stripe granule; power of two
//  vcache_size_p                 4096  per-vcache words (block-memory mode)
//  host_x_cord_p / host_y_cord_p 0/1   host endpoint for EVA[31:30]==2'b11, striping off
// PORTS
//  clk_i          in   1      clock
//  reset_n_i      in   1      reset, synchronous, active-low
//  cfg_v_i        in   1      config write strobe
//  cfg_data_i     in   2      [0] dram_enable, [1] xor_hash_enable
//  cfg_ready_o    out  1      config write accepted this cycle
//  v_i            in   1      request valid
//  eva_i          in   32     byte EVA
//  tgo_x_i/tgo_y_i in  x/y    tile-group origin, sampled with eva_i
//  ready_o        out  1      request accepted when v_i & ready_o
//  v_o            out  1      translation valid
//  x_cord_o/y_cord_o out x/y  destination
//  epa_o          out  addr   endpoint word address
//  is_invalid_addr_o out 1    EVA maps to no NPA; x/y/epa are 0
//  yumi_i         in   1      consumer takes output (only while v_o)
//  stats_o        out  4x32   {invalid,tile_group,global,dram} counters
// BEHAVIOUR
//  - Reset: all valids 0, cfg = 2'b01 (striping on, xor off), x/y/epa/invalid outputs 0, counters 0. Reset
//    mid-operation drops in-flight requests; no output follows.
//  - Two stages: S1 register (eva, tgo, cfg snapshot), S2 output register. Latency 2: accepted in cycle t -> v_o in
//    t+2 absent backpressure. Throughput 1/cycle. ready_o = ~cfg_v_i & (~s1_v | ~s2_v | yumi_i); no combinational
//    path v_i->v_o. Output stable while v_o & ~yumi_i.
//  - Config: cfg_ready_o = ~s1_v & ~s2_v. A pending cfg_v_i blocks new requests (ready_o=0), so pipeline drains, then
//    cfg is written; request in same cycle is not accepted. Each request uses the cfg held when it entered S1.
//  - Region: DRAM EVA[31]; global EVA[31:30]=01; tile-group EVA[31:29]=001; else invalid.
//  - DRAM, striping on: off=log2(block); lgx=log2(num_tiles_x_p); banks=num_tiles_x_p*num_dram_rows_p, lgb=log2(banks).
//    b=EVA[30:2+off]; bank=b[lgb-1:0]; idx=b>>lgb. xor on: bank ^= idx[lgb-1:0]. x=bank[lgx-1:0];
//    2 rows: y = bank[lgx] ? num_tiles_y_p+1 : 0; 1 row: y=num_tiles_y_p+1. epa={0,idx,EVA[2+:off]}, zero-extended,
//    MSB forced 0.
//  - DRAM, striping off: EVA[30]=1 -> host: x/y=host params, epa={1'b1,EVA[2+:addr_width_p-1]}. Else lgv=log2(vcache_size_p):
//    x=EVA[2+lgv+:lgx], y from EVA[2+lgv+lgx] as row bit (ignored, bottom, if 1 row), epa=EVA[2+:lgv] zero-extended.
//  - Global: x,y,addr from global-addr struct fields, epa zero-extended. Tile-group: x/y = field + tgo, truncated
//    to coordinate width (wrap-around, no error); epa zero-extended.
//  - Simultaneous yumi_i and v_i with full pipeline: both stages advance, request accepted.
// CONFIGURATION
//  BSG_MANYCORE_EVA_NPA_STATS_EN defined: four 32-bit counters increment on each yumi_i by output region,
//  saturating at 2^32-1. Undefined: no counters, stats_o tied 0.
// STRUCTURE
//  - bsg_manycore_pkg: eva region enum (e_eva_dram/global/tile_group/invalid), cfg struct
//    {xor_hash_enable, dram_enable}; reuse existing global/tile-group addr struct macros.
//  - Sub-module bsg_manycore_eva_dram_hash: combinational b->{bank,idx} stripe plus optional XOR; used in S1->S2.
// TESTING (num_tiles_x=16, rows=2, block=8, tiles_y=8)
//  1 Reset cfg, EVA 0x8000_0020 -> x=1,y=0,epa=0 at t+2.
//  2 EVA 0x8000_0400: xor off -> x=0,y=0,epa=0x8; cfg=2'b11 then same EVA -> x=1,y=0,epa=0x8.
//  3 cfg=2'b00, EVA 0xC000_0010 -> x=0,y=1,epa=0x800_0004; EVA 0x0000_0000 -> is_invalid_addr_o=1, x/y/epa=0.
//  4 tgo=(2,3), tile-group EVA x=1,y=1,addr=0x10 -> x=3,y=4,epa=0x10; tgo x=127 plus x=1 -> x=0.
//  5 Back-to-back 8 requests, yumi_i random 50%: in-order, none lost/duplicated, outputs stable when stalled.
//  6 cfg_v_i with 2 in flight: cfg_ready_o after drain, ready_o=0 meanwhile; reset_n_i=0 mid-stream -> v_o=0 next cycle.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore EVA->NPA translation pipe: region classes,
// runtime DRAM-mode config and the global / tile-group EVA field layouts.
package bsg_manycore_pkg;

  localparam int unsigned eva_width_gp             = 32;
  localparam int unsigned max_x_cord_width_gp      = 7;
  localparam int unsigned max_y_cord_width_gp      = 7;
  localparam int unsigned global_addr_width_gp     = eva_width_gp - 2 - max_x_cord_width_gp - max_y_cord_width_gp - 2;
  localparam int unsigned tile_group_addr_width_gp = eva_width_gp - 3 - max_x_cord_width_gp - max_y_cord_width_gp - 2;

  typedef enum logic [1:0] {
    e_eva_dram       = 2'd0,
    e_eva_global     = 2'd1,
    e_eva_tile_group = 2'd2,
    e_eva_invalid    = 2'd3
  } eva_region_e;

  typedef struct packed {
    logic xor_hash_enable;
    logic dram_enable;
  } eva_npa_cfg_s;

  localparam eva_npa_cfg_s cfg_reset_gp = '{xor_hash_enable: 1'b0, dram_enable: 1'b1};

  typedef struct packed {
    logic [1:0]                          remote;
    logic [max_y_cord_width_gp-1:0]      y_cord;
    logic [max_x_cord_width_gp-1:0]      x_cord;
    logic [global_addr_width_gp-1:0]     addr;
    logic [1:0]                          low_bits;
  } bsg_manycore_global_addr_s;

  typedef struct packed {
    logic [2:0]                          remote;
    logic [max_y_cord_width_gp-1:0]      y_cord;
    logic [max_x_cord_width_gp-1:0]      x_cord;
    logic [tile_group_addr_width_gp-1:0] addr;
    logic [1:0]                          low_bits;
  } bsg_manycore_tile_group_addr_s;

  // Region decode from the three EVA MSBs.
  function automatic eva_region_e eva_region(input logic [2:0] top_bits);
    if (top_bits[2])      return e_eva_dram;
    else if (top_bits[1]) return e_eva_global;
    else if (top_bits[0]) return e_eva_tile_group;
    else                  return e_eva_invalid;
  endfunction

endpackage

// File: rtl/bsg_manycore_eva_dram_hash.sv
// Stripes a DRAM block number across banks, optionally folding the row index
// back into the bank select with an XOR to spread power-of-two strides.
module bsg_manycore_eva_dram_hash #(
  parameter int unsigned b_width_p  = 26,
  parameter int unsigned lg_banks_p = 5
) (
  input  logic [b_width_p-1:0]            b,
  input  logic                            xor_en,
  output logic [lg_banks_p-1:0]           bank,
  output logic [b_width_p-lg_banks_p-1:0] idx
);

  assign idx  = b[b_width_p-1:lg_banks_p];
  assign bank = b[lg_banks_p-1:0] ^ ({lg_banks_p{xor_en}} & idx[lg_banks_p-1:0]);

endmodule

// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// Two-stage valid/ready EVA->NPA translator with runtime DRAM mode.
// Optional per-region served counters: define BSG_MANYCORE_EVA_NPA_STATS_EN.
module bsg_manycore_eva_to_npa_pipe
  import bsg_manycore_pkg::*;
#(
  parameter int unsigned data_width_p                 = 32,
  parameter int unsigned addr_width_p                 = 28,
  parameter int unsigned x_cord_width_p               = 7,
  parameter int unsigned y_cord_width_p               = 7,
  parameter int unsigned num_tiles_x_p                = 16,
  parameter int unsigned num_tiles_y_p                = 8,
  parameter int unsigned num_dram_rows_p              = 2,
  parameter int unsigned vcache_block_size_in_words_p = 8,
  parameter int unsigned vcache_size_p                = 4096,
  parameter int unsigned host_x_cord_p                = 0,
  parameter int unsigned host_y_cord_p                = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      cfg_v_i,
  input  logic [1:0]                cfg_data_i,
  output logic                      cfg_ready_o,
  input  logic                      v_i,
  input  logic [data_width_p-1:0]   eva_i,
  input  logic [x_cord_width_p-1:0] tgo_x_i,
  input  logic [y_cord_width_p-1:0] tgo_y_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [x_cord_width_p-1:0] x_cord_o,
  output logic [y_cord_width_p-1:0] y_cord_o,
  output logic [addr_width_p-1:0]   epa_o,
  output logic                      is_invalid_addr_o,
  input  logic                      yumi_i,
  output logic [127:0]              stats_o
);

  localparam int unsigned off_lp     = $clog2(vcache_block_size_in_words_p);
  localparam int unsigned lgx_lp     = $clog2(num_tiles_x_p);
  localparam int unsigned lgb_lp     = $clog2(num_tiles_x_p * num_dram_rows_p);
  localparam int unsigned lgv_lp     = $clog2(vcache_size_p);
  localparam int unsigned b_width_lp = 29 - off_lp;
  localparam int unsigned idx_width_lp = b_width_lp - lgb_lp;
  localparam logic [y_cord_width_p-1:0] bottom_y_lp = y_cord_width_p'(num_tiles_y_p + 1);

  eva_npa_cfg_s              cfg_r, s1_cfg;
  logic                      s1_v, s2_v, s2_ready, s2_load, accept;
  logic [data_width_p-1:0]   s1_eva;
  logic [x_cord_width_p-1:0] s1_tgo_x, nx_x;
  logic [y_cord_width_p-1:0] s1_tgo_y, nx_y;
  logic [addr_width_p-1:0]   nx_epa;
  logic                      nx_invalid;
  eva_region_e               nx_region, s2_region;
  logic [lgb_lp-1:0]         hash_bank;
  logic [idx_width_lp-1:0]   hash_idx;
  bsg_manycore_global_addr_s     g;
  bsg_manycore_tile_group_addr_s tg;
  logic                      unused_bits;

  assign s2_ready    = ~s2_v | yumi_i;
  assign s2_load     = s1_v & s2_ready;
  assign ready_o     = ~cfg_v_i & (~s1_v | s2_ready);
  assign accept      = v_i & ready_o;
  assign cfg_ready_o = ~s1_v & ~s2_v;
  assign v_o         = s2_v;

  assign g  = s1_eva;
  assign tg = s1_eva;
  assign unused_bits = ^{s1_eva[1:0], g.remote, g.low_bits, tg.remote, tg.low_bits};

  bsg_manycore_eva_dram_hash #(
    .b_width_p  (b_width_lp),
    .lg_banks_p (lgb_lp)
  ) dram_hash (
    .b      (s1_eva[30:2+off_lp]),
    .xor_en (s1_cfg.xor_hash_enable),
    .bank   (hash_bank),
    .idx    (hash_idx)
  );

  // S1 payload needs no reset; it is qualified by s1_v.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_eva   <= eva_i;
      s1_tgo_x <= tgo_x_i;
      s1_tgo_y <= tgo_y_i;
      s1_cfg   <= cfg_r;
    end
  end

  // Translation of the S1 request into the next output word.
  always_comb begin
    nx_x       = '0;
    nx_y       = '0;
    nx_epa     = '0;
    nx_invalid = 1'b0;
    nx_region  = eva_region(s1_eva[31:29]);
    unique case (nx_region)
      e_eva_dram: begin
        if (s1_cfg.dram_enable) begin
          nx_x   = x_cord_width_p'(hash_bank[lgx_lp-1:0]);
          nx_y   = ((num_dram_rows_p == 1) || hash_bank[lgb_lp-1]) ? bottom_y_lp : '0;
          nx_epa = addr_width_p'({hash_idx, s1_eva[2 +: off_lp]});
          nx_epa[addr_width_p-1] = 1'b0;
        end else if (s1_eva[30]) begin
          nx_x   = x_cord_width_p'(host_x_cord_p);
          nx_y   = y_cord_width_p'(host_y_cord_p);
          nx_epa = {1'b1, s1_eva[2 +: addr_width_p-1]};
        end else begin
          nx_x   = x_cord_width_p'(s1_eva[2+lgv_lp +: lgx_lp]);
          nx_y   = ((num_dram_rows_p == 1) || s1_eva[2+lgv_lp+lgx_lp]) ? bottom_y_lp : '0;
          nx_epa = addr_width_p'(s1_eva[2 +: lgv_lp]);
        end
      end
      e_eva_global: begin
        nx_x   = x_cord_width_p'(g.x_cord);
        nx_y   = y_cord_width_p'(g.y_cord);
        nx_epa = addr_width_p'(g.addr);
      end
      e_eva_tile_group: begin
        nx_x   = x_cord_width_p'(x_cord_width_p'(tg.x_cord) + s1_tgo_x);
        nx_y   = y_cord_width_p'(y_cord_width_p'(tg.y_cord) + s1_tgo_y);
        nx_epa = addr_width_p'(tg.addr);
      end
      e_eva_invalid: nx_invalid = 1'b1;
    endcase
  end

  // Valids, config and the output register; outputs hold while stalled.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s1_v              <= 1'b0;
      s2_v              <= 1'b0;
      cfg_r             <= cfg_reset_gp;
      x_cord_o          <= '0;
      y_cord_o          <= '0;
      epa_o             <= '0;
      is_invalid_addr_o <= 1'b0;
      s2_region         <= e_eva_invalid;
    end else begin
      if (cfg_v_i && cfg_ready_o) cfg_r <= eva_npa_cfg_s'(cfg_data_i);
      if (accept)       s1_v <= 1'b1;
      else if (s2_load) s1_v <= 1'b0;
      if (s2_load) begin
        s2_v              <= 1'b1;
        x_cord_o          <= nx_x;
        y_cord_o          <= nx_y;
        epa_o             <= nx_epa;
        is_invalid_addr_o <= nx_invalid;
        s2_region         <= nx_region;
      end else if (yumi_i) begin
        s2_v <= 1'b0;
      end
    end
  end

`ifdef BSG_MANYCORE_EVA_NPA_STATS_EN
  logic [3:0][31:0] stat_r;

  // Saturating served-request counters indexed by output region.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stat_r <= '0;
    end else if (s2_v && yumi_i && (stat_r[s2_region] != '1)) begin
      stat_r[s2_region] <= stat_r[s2_region] + 32'd1;
    end
  end

  assign stats_o = stat_r;
`else
  logic unused_region;
  assign unused_region = ^s2_region;
  assign stats_o       = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_eva_to_npa_pipe.sv
// Randomized + directed bench for bsg_manycore_eva_to_npa_pipe against an
// arithmetic reference model and an in-order scoreboard.
module tb_bsg_manycore_eva_to_npa_pipe;

  logic         clk_i = 1'b0;
  logic         reset_n_i, cfg_v_i, cfg_ready_o;
  logic [1:0]   cfg_data_i;
  logic         v_i, ready_o, v_o, is_invalid_addr_o, yumi_i;
  logic [31:0]  eva_i;
  logic [6:0]   tgo_x_i, tgo_y_i, x_cord_o, y_cord_o;
  logic [27:0]  epa_o;
  logic [127:0] stats_o;

  always #5 clk_i = ~clk_i;

  bsg_manycore_eva_to_npa_pipe dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cfg_v_i(cfg_v_i), .cfg_data_i(cfg_data_i), .cfg_ready_o(cfg_ready_o),
    .v_i(v_i), .eva_i(eva_i), .tgo_x_i(tgo_x_i), .tgo_y_i(tgo_y_i), .ready_o(ready_o),
    .v_o(v_o), .x_cord_o(x_cord_o), .y_cord_o(y_cord_o), .epa_o(epa_o),
    .is_invalid_addr_o(is_invalid_addr_o), .yumi_i(yumi_i), .stats_o(stats_o)
  );

  typedef struct {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [27:0] epa;
    logic        inv;
    int          region;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc, n_checks, n_bad;
  logic [1:0]  mcfg;
  int unsigned mstat[4];
  logic        last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference translation for 16x2 DRAM banks, 8-word blocks, 4096-word vcaches, 8 tile rows.
  function automatic exp_t model(input logic [31:0] eva, input logic [6:0] tx, input logic [6:0] ty,
                                 input logic [1:0] cfg);
    exp_t e;
    longint unsigned a, word, blk, bank, idx;
    a = longint'(eva);
    word = (a % 64'h8000_0000) / 4;
    e.x = '0; e.y = '0; e.epa = '0; e.inv = 1'b0; e.acc = 0;
    if (a >= 64'h8000_0000) begin
      e.region = 0;
      if (cfg[0]) begin
        blk  = word / 8;
        bank = blk % 32;
        idx  = blk / 32;
        if (cfg[1]) bank = bank ^ (idx % 32);
        e.x   = 7'(bank % 16);
        e.y   = (bank >= 16) ? 7'd9 : 7'd0;
        e.epa = 28'((idx * 8 + word % 8) % (64'd1 << 27));
      end else if (a >= 64'hC000_0000) begin
        e.x   = 7'd0;
        e.y   = 7'd1;
        e.epa = 28'((64'd1 << 27) + word % (64'd1 << 27));
      end else begin
        e.x   = 7'((word / 4096) % 16);
        e.y   = (((word / 65536) % 2) == 1) ? 7'd9 : 7'd0;
        e.epa = 28'(word % 4096);
      end
    end else if (a >= 64'h4000_0000) begin
      e.region = 1;
      e.x   = 7'((a / 65536) % 128);
      e.y   = 7'((a / (64'd1 << 23)) % 128);
      e.epa = 28'((a / 4) % 16384);
    end else if (a >= 64'h2000_0000) begin
      e.region = 2;
      e.x   = 7'(((a / 32768) % 128 + longint'(tx)) % 128);
      e.y   = 7'(((a / (64'd1 << 22)) % 128 + longint'(ty)) % 128);
      e.epa = 28'((a / 4) % 8192);
    end else begin
      e.region = 3;
      e.inv    = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] tg_eva(input int unsigned x, input int unsigned y, input int unsigned addr);
    return 32'((32'd1 << 29) | (y << 22) | (x << 15) | (addr << 2));
  endfunction

  function automatic logic [31:0] rand_eva();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       r[31]    = 1'b1;
      1:       r[31:30] = 2'b01;
      2:       r[31:29] = 3'b001;
      default: r[31:29] = 3'b000;
    endcase
    return r;
  endfunction

  // One clock: called and returning at a falling edge.
  task automatic step(input logic vin, input logic [31:0] eva, input logic [6:0] tx, input logic [6:0] ty,
                      input logic yw);
    logic exp_v, took;
    exp_t e;
    exp_v = (q.size() > 0) && (cyc - q[0].acc >= 2);
    check("v_o", 64'(v_o), 64'(exp_v));
    check("cfg_ready_o", 64'(cfg_ready_o), 64'(q.size() == 0));
    if (exp_v) begin
      check("x_cord_o", 64'(x_cord_o), 64'(q[0].x));
      check("y_cord_o", 64'(y_cord_o), 64'(q[0].y));
      check("epa_o", 64'(epa_o), 64'(q[0].epa));
      check("is_invalid", 64'(is_invalid_addr_o), 64'(q[0].inv));
    end
    v_i = vin; eva_i = eva; tgo_x_i = tx; tgo_y_i = ty;
    yumi_i = yw & v_o;
    #1;
    check("ready_o", 64'(ready_o), 64'(!cfg_v_i && (q.size() < 2 || yumi_i)));
    took     = v_o & yumi_i;
    last_acc = v_i & ready_o;
    if (took && q.size() > 0) begin
      mstat[q[0].region]++;
      void'(q.pop_front());
    end
    if (last_acc) begin
      e = model(eva, tx, ty, mcfg);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    v_i = 1'b0; yumi_i = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] eva, input logic [6:0] tx, input logic [6:0] ty,
                          input logic [6:0] ex, input logic [6:0] ey, input logic [27:0] eepa, input logic einv);
    step(1'b1, eva, tx, ty, 1'b0);
    check({tag, "_accept"}, 64'(last_acc), 64'(1));
    step(1'b0, 32'd0, 7'd0, 7'd0, 1'b0);
    check({tag, "_v"}, 64'(v_o), 64'(1));
    check({tag, "_x"}, 64'(x_cord_o), 64'(ex));
    check({tag, "_y"}, 64'(y_cord_o), 64'(ey));
    check({tag, "_epa"}, 64'(epa_o), 64'(eepa));
    check({tag, "_inv"}, 64'(is_invalid_addr_o), 64'(einv));
    step(1'b0, 32'd0, 7'd0, 7'd0, 1'b1);
    step(1'b0, 32'd0, 7'd0, 7'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 32'd0, 7'd0, 7'd0, 1'b1);
    check("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic write_cfg(input logic [1:0] val);
    cfg_v_i = 1'b1; cfg_data_i = val;
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b1, rand_eva(), 7'd0, 7'd0, 1'b1);
    check("cfg_drain", 64'(q.size()), 64'(0));
    step(1'b1, rand_eva(), 7'd0, 7'd0, 1'b0);
    check("cfg_req_refused", 64'(last_acc), 64'(0));
    mcfg = val; cfg_v_i = 1'b0;
  endtask

  task automatic run_random(input int n, input int vpct);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < vpct, rand_eva(), 7'($urandom), 7'($urandom), $urandom_range(0, 1) == 1);
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_checks = 0; n_bad = 0; cyc = 0; mcfg = 2'b01;
    for (int r = 0; r < 4; r++) mstat[r] = 0;
    reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_data_i = 2'b00; v_i = 1'b0; eva_i = '0;
    tgo_x_i = '0; tgo_y_i = '0; yumi_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_v_o", 64'(v_o), 64'(0));
    check("rst_x", 64'(x_cord_o), 64'(0));
    check("rst_y", 64'(y_cord_o), 64'(0));
    check("rst_epa", 64'(epa_o), 64'(0));
    check("rst_inv", 64'(is_invalid_addr_o), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready_o), 64'(1));
    check("rst_stats", 64'(stats_o != '0), 64'(0));
    reset_n_i = 1'b1;

    directed("dram_stripe", 32'h8000_0020, 7'd0, 7'd0, 7'd1, 7'd0, 28'h0, 1'b0);
    directed("dram_bank16", 32'h8000_0200, 7'd0, 7'd0, 7'd0, 7'd9, 28'h0, 1'b0);
    directed("dram_noxor",  32'h8000_0400, 7'd0, 7'd0, 7'd0, 7'd0, 28'h8, 1'b0);
    write_cfg(2'b11);
    directed("dram_xor",    32'h8000_0400, 7'd0, 7'd0, 7'd1, 7'd0, 28'h8, 1'b0);
    write_cfg(2'b00);
    directed("host",        32'hC000_0010, 7'd0, 7'd0, 7'd0, 7'd1, 28'h800_0004, 1'b0);
    directed("invalid",     32'h0000_0000, 7'd0, 7'd0, 7'd0, 7'd0, 28'h0, 1'b1);
    directed("tile_group",  tg_eva(1, 1, 16), 7'd2, 7'd3, 7'd3, 7'd4, 28'h10, 1'b0);
    directed("tg_wrap",     tg_eva(1, 0, 0), 7'd127, 7'd0, 7'd0, 7'd0, 28'h0, 1'b0);

    write_cfg(2'b01);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 8; i++) begin
      step(1'b1, rand_eva(), 7'($urandom), 7'($urandom), $urandom_range(0, 1) == 1);
      if (last_acc) cnt++;
    end
    check("b2b_count", 64'(cnt), 64'(8));
    drain();

    run_random(200, 70);
    write_cfg(2'b11); run_random(200, 90);
    write_cfg(2'b00); run_random(200, 60);
    write_cfg(2'b10); run_random(200, 100);

    // Config request with two requests in flight.
    step(1'b1, rand_eva(), 7'd5, 7'd6, 1'b0);
    step(1'b1, rand_eva(), 7'd5, 7'd6, 1'b0);
    check("inflight2", 64'(q.size()), 64'(2));
    write_cfg(2'b11);

    // Reset with a full pipe: nothing may come out afterwards.
    step(1'b1, rand_eva(), 7'd1, 7'd1, 1'b0);
    step(1'b1, rand_eva(), 7'd1, 7'd1, 1'b0);
    reset_n_i = 1'b0;
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    check("midrst_v_o", 64'(v_o), 64'(0));
    check("midrst_cfg_ready", 64'(cfg_ready_o), 64'(1));
    check("midrst_epa", 64'(epa_o), 64'(0));
    reset_n_i = 1'b1;
    q.delete();
    mcfg = 2'b01;
    for (int r = 0; r < 4; r++) mstat[r] = 0;
    step(1'b0, 32'd0, 7'd0, 7'd0, 1'b1);
    step(1'b0, 32'd0, 7'd0, 7'd0, 1'b1);
    directed("post_rst_cfg", 32'h8000_0400, 7'd0, 7'd0, 7'd0, 7'd0, 28'h8, 1'b0);
    run_random(100, 80);

`ifdef BSG_MANYCORE_EVA_NPA_STATS_EN
    for (int r = 0; r < 4; r++) check("stats", 64'(stats_o[r*32 +: 32]), 64'(mstat[r]));
`else
    check("stats_off", 64'(stats_o != '0), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
